// File: rtl/multdiv_sched.sv
// Sequencer for the shared multi-cycle multiply/divide unit: latches operands, pulses start, stalls
// the pipeline until ready, emits a one-cycle writeback. Define MDSCHED_TIMEOUT_EN to enable the watchdog.
module multdiv_sched #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CNT_W   = 6,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_div,
  input  logic [DATA_W-1:0] issue_a,
  input  logic [DATA_W-1:0] issue_b,
  input  logic [4:0]        issue_rd,
  input  logic              flush,
  output logic              stall,
  output logic              md_ctrl_mult,
  output logic              md_ctrl_div,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  input  logic [DATA_W-1:0] md_result,
  input  logic              md_exception,
  input  logic              md_resultRDY,
  output logic              wb_valid,
  output logic [4:0]        wb_reg,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic [CNT_W-1:0]  last_latency
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

`ifdef MDSCHED_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [4:0]        EXC_REG   = 5'd30;
  localparam logic [DATA_W-1:0] EXC_MULT  = DATA_W'(4);
  localparam logic [DATA_W-1:0] EXC_DIV   = DATA_W'(5);

  state_t            state, state_nxt;
  logic              op_div;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timed_out;
  logic              finish;
  logic              exc;

  assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign timed_out = WDOG_EN && (state == WAIT) && !md_resultRDY && (cnt_inc >= CNT_LIMIT);
  assign finish    = (state == WAIT) && !flush && (md_resultRDY || timed_out);
  assign exc       = md_resultRDY ? md_exception : 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state; stall and start pulses depend on flush so an abort takes effect this cycle.
  always_comb begin
    state_nxt    = state;
    stall        = 1'b0;
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (issue_valid && !flush) begin
          stall     = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        stall = 1'b1;
        if (flush) begin
          state_nxt = IDLE;
        end else begin
          md_ctrl_mult = !op_div;
          md_ctrl_div  = op_div;
          state_nxt    = WAIT;
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (flush)       state_nxt = IDLE;
        else if (finish) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush && state != DONE) stall = 1'b0;
  end

  // Operand, counter and writeback registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_a         <= '0;
      md_b         <= '0;
      op_div       <= 1'b0;
      rd_q         <= '0;
      cnt          <= '0;
      wb_valid     <= 1'b0;
      wb_reg       <= '0;
      wb_data      <= '0;
      last_latency <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (state == IDLE && issue_valid && !flush) begin
        md_a   <= issue_a;
        md_b   <= issue_b;
        op_div <= issue_div;
        rd_q   <= issue_rd;
      end
      if (state == START) cnt <= '0;
      if (state == WAIT && !finish) cnt <= cnt_inc;
      if (finish) begin
        last_latency <= cnt_inc;
        if (exc) begin
          wb_valid <= 1'b1;
          wb_reg   <= EXC_REG;
          wb_data  <= op_div ? EXC_DIV : EXC_MULT;
        end else begin
          wb_valid <= (rd_q != 5'd0);
          wb_reg   <= rd_q;
          wb_data  <= md_result;
        end
      end
    end
  end

endmodule

// File: tb/tb_multdiv_sched.sv
// Directed self-checking bench for multdiv_sched: normal ops, exceptions, $r0 suppression,
// flush/abort with stale ready, back-to-back issue, no-watchdog hang with counter saturation, reset.
module tb_multdiv_sched;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_div = 1'b0;
  logic [DATA_W-1:0] issue_a = '0;
  logic [DATA_W-1:0] issue_b = '0;
  logic [4:0]        issue_rd = '0;
  logic              flush = 1'b0;
  logic              stall;
  logic              md_ctrl_mult;
  logic              md_ctrl_div;
  logic [DATA_W-1:0] md_a;
  logic [DATA_W-1:0] md_b;
  logic [DATA_W-1:0] md_result = '0;
  logic              md_exception = 1'b0;
  logic              md_resultRDY = 1'b0;
  logic              wb_valid;
  logic [4:0]        wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              busy;
  logic [CNT_W-1:0]  last_latency;

  int n_tests = 0;
  int n_fail  = 0;

  multdiv_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W), .TIMEOUT(40)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_div(issue_div), .issue_a(issue_a), .issue_b(issue_b),
    .issue_rd(issue_rd), .flush(flush), .stall(stall),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div), .md_a(md_a), .md_b(md_b),
    .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .busy(busy), .last_latency(last_latency)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present an op for one cycle from IDLE; returns in START.
  task automatic issue(input logic d, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    issue_valid = 1'b1; issue_div = d; issue_a = a; issue_b = b; issue_rd = rd;
    tick();
    issue_valid = 1'b0;
  endtask

  // From START: ready is raised on WAIT cycle 'lat'; returns in DONE.
  task automatic complete(input int lat, input logic [31:0] res, input logic e);
    repeat (lat) tick();
    md_resultRDY = 1'b1; md_result = res; md_exception = e;
    tick();
    md_resultRDY = 1'b0; md_exception = 1'b0;
  endtask

  initial begin
    repeat (2) tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_md_a", md_a, 0);
    check("rst_wb_valid", 32'(wb_valid), 0);
    reset = 1'b1;
    tick();
    check("rst_wb_data", wb_data, 0);
    check("rst_latency", 32'(last_latency), 0);
    check("rst_stall", 32'(stall), 0);

    // mult 6*7 -> r5, ready 17 cycles after START
    issue_valid = 1'b1; issue_div = 1'b0; issue_a = 6; issue_b = 7; issue_rd = 5;
    #1 check("t1_stall_issue", 32'(stall), 1);
    tick();
    issue_valid = 1'b0; issue_a = 0; issue_b = 0;
    check("t1_start_mult", 32'(md_ctrl_mult), 1);
    check("t1_start_div", 32'(md_ctrl_div), 0);
    check("t1_md_a", md_a, 6);
    check("t1_md_b", md_b, 7);
    tick();
    check("t1_pulse_once", 32'(md_ctrl_mult), 0);
    check("t1_stall_wait", 32'(stall), 1);
    check("t1_md_a_held", md_a, 6);
    complete(16, 42, 1'b0);
    check("t1_wb_valid", 32'(wb_valid), 1);
    check("t1_wb_reg", 32'(wb_reg), 5);
    check("t1_wb_data", wb_data, 42);
    check("t1_latency", 32'(last_latency), 17);
    check("t1_stall_done", 32'(stall), 0);
    tick();
    check("t1_wb_one_cycle", 32'(wb_valid), 0);
    check("t1_idle", 32'(busy), 0);

    // div 1/0 with exception -> r30 = 5
    issue(1'b1, 1, 0, 3);
    check("t2_start_div", 32'(md_ctrl_div), 1);
    check("t2_start_mult", 32'(md_ctrl_mult), 0);
    complete(5, 32'hdead_beef, 1'b1);
    check("t2_wb_valid", 32'(wb_valid), 1);
    check("t2_wb_reg", 32'(wb_reg), 30);
    check("t2_wb_data", wb_data, 5);
    check("t2_latency", 32'(last_latency), 5);
    tick();

    // mult to r0: no writeback, stall released for exactly one DONE cycle
    issue(1'b0, 9, 11, 0);
    complete(3, 99, 1'b0);
    check("t3_wb_valid_r0", 32'(wb_valid), 0);
    check("t3_stall_done", 32'(stall), 0);
    check("t3_busy_done", 32'(busy), 1);
    check("t3_latency", 32'(last_latency), 3);
    tick();
    check("t3_idle", 32'(busy), 0);

    // flush on WAIT cycle 4, then stale ready
    issue(1'b0, 2, 3, 9);
    repeat (4) tick();
    flush = 1'b1;
    #1 check("t4_stall_flush", 32'(stall), 0);
    tick();
    flush = 1'b0;
    check("t4_idle", 32'(busy), 0);
    check("t4_no_wb", 32'(wb_valid), 0);
    repeat (9) tick();
    md_resultRDY = 1'b1; md_result = 77;
    tick();
    md_resultRDY = 1'b0;
    check("t4_stale_wb", 32'(wb_valid), 0);
    check("t4_stale_busy", 32'(busy), 0);
    check("t4_latency_kept", 32'(last_latency), 3);

    // flush in START: no pulse; flush in IDLE: issue ignored
    issue(1'b1, 4, 2, 6);
    flush = 1'b1;
    #1 check("t4b_no_pulse", 32'(md_ctrl_div), 0);
    check("t4b_stall", 32'(stall), 0);
    issue_valid = 1'b1;
    tick();
    check("t4b_idle", 32'(busy), 0);
    check("t4b_idle_flush_stall", 32'(stall), 0);
    tick();
    issue_valid = 1'b0; flush = 1'b0;
    check("t4b_stay_idle", 32'(busy), 0);

    // back-to-back: div -> r7 then mult -> r8 issued during DONE; flush in DONE ignored
    issue(1'b1, 100, 7, 7);
    complete(2, 14, 1'b0);
    issue_valid = 1'b1; issue_div = 1'b0; issue_a = 3; issue_b = 5; issue_rd = 8;
    flush = 1'b1;
    #1 check("t5_wb_valid1", 32'(wb_valid), 1);
    check("t5_wb_reg1", 32'(wb_reg), 7);
    check("t5_wb_data1", wb_data, 14);
    check("t5_stall_done", 32'(stall), 0);
    tick();
    flush = 1'b0;
    #1 check("t5_idle_stall", 32'(stall), 1);
    check("t5_idle_busy", 32'(busy), 0);
    tick();
    issue_valid = 1'b0;
    check("t5_second_pulse", 32'(md_ctrl_mult), 1);
    check("t5_md_a2", md_a, 3);
    complete(4, 15, 1'b0);
    check("t5_wb_reg2", 32'(wb_reg), 8);
    check("t5_wb_data2", wb_data, 15);
    check("t5_latency2", 32'(last_latency), 4);
    tick();

`ifdef MDSCHED_TIMEOUT_EN
    // watchdog: ready never arrives
    issue(1'b0, 1, 1, 4);
    repeat (41) tick();
    check("t6_wdog_valid", 32'(wb_valid), 1);
    check("t6_wdog_reg", 32'(wb_reg), 30);
    check("t6_wdog_data", wb_data, 4);
    check("t6_wdog_latency", 32'(last_latency), 40);
    tick();
`else
    // no watchdog: still stalled at cycle 100; late ready reports saturated latency
    issue(1'b0, 1, 1, 4);
    repeat (100) tick();
    check("t6_stall_100", 32'(stall), 1);
    check("t6_busy_100", 32'(busy), 1);
    md_resultRDY = 1'b1; md_result = 1;
    tick();
    md_resultRDY = 1'b0;
    check("t6_late_wb_reg", 32'(wb_reg), 4);
    check("t6_latency_sat", 32'(last_latency), 63);
    tick();
`endif

    // async reset mid-operation
    issue(1'b1, 8, 2, 12);
    repeat (3) tick();
    reset = 1'b0;
    #1 check("t7_rst_busy", 32'(busy), 0);
    check("t7_rst_stall", 32'(stall), 0);
    check("t7_rst_md_a", md_a, 0);
    check("t7_rst_latency", 32'(last_latency), 0);
    tick();
    reset = 1'b1;
    md_resultRDY = 1'b1;
    tick();
    md_resultRDY = 1'b0;
    check("t7_stale_after_rst", 32'(wb_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
